// File: rtl/ff_mode_pkg.sv
// Shared operation encodings for the mode-select register.
// Used by ff_mode_reg and its bench.
package ff_mode_pkg;

   localparam int unsigned MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD   = 3'b000;
   localparam logic [MODE_W-1:0] MODE_LOAD   = 3'b001;
   localparam logic [MODE_W-1:0] MODE_TOGGLE = 3'b010;
   localparam logic [MODE_W-1:0] MODE_SET    = 3'b011;
   localparam logic [MODE_W-1:0] MODE_CLR    = 3'b100;
   localparam logic [MODE_W-1:0] MODE_SHL    = 3'b101;
   localparam logic [MODE_W-1:0] MODE_SHR    = 3'b110;
   localparam logic [MODE_W-1:0] MODE_ROL    = 3'b111;

endpackage

// File: rtl/ff_mode_cell.sv
// One storage bit with asynchronous active-high reset to a per-bit reset value.
module ff_mode_cell #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= RST_VAL;
      else     q <= d;
   end

endmodule

// File: rtl/ff_mode_reg.sv
// WIDTH-bit register with per-cycle hold/load/toggle/set/clear/shift/rotate select.
// Optional CHG output (Q changed on the last edge) when FF_MODE_REG_CHG_EN is defined.
module ff_mode_reg
   import ff_mode_pkg::*;
#(
   parameter int unsigned        WIDTH   = 8,
   parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [MODE_W-1:0] MODE,
   input  logic [WIDTH-1:0]  D,
   input  logic              SIN,
   output logic [WIDTH-1:0]  Q,
   output logic [WIDTH-1:0]  QN,
   output logic              SOUT
`ifdef FF_MODE_REG_CHG_EN
   ,
   output logic              CHG
`endif
);

   logic [WIDTH-1:0] q_next;
   logic             sout_next;

   // Next state; an unknown MODE falls into the default arm and holds.
   always_comb begin
      q_next    = Q;
      sout_next = SOUT;
      if (EN) begin
         case (MODE)
            MODE_HOLD:   q_next = Q;
            MODE_LOAD:   q_next = D;
            MODE_TOGGLE: q_next = Q ^ D;
            MODE_SET:    q_next = Q | D;
            MODE_CLR:    q_next = Q & ~D;
            MODE_SHL: begin
               q_next    = {Q[WIDTH-2:0], SIN};
               sout_next = Q[WIDTH-1];
            end
            MODE_SHR: begin
               q_next    = {SIN, Q[WIDTH-1:1]};
               sout_next = Q[0];
            end
            MODE_ROL: begin
               q_next    = {Q[WIDTH-2:0], Q[WIDTH-1]};
               sout_next = Q[WIDTH-1];
            end
            default: begin
               q_next    = Q;
               sout_next = SOUT;
            end
         endcase
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      ff_mode_cell #(
         .RST_VAL (RST_VAL[i])
      ) u_cell (
         .clk (CLK),
         .rst (RST),
         .d   (q_next[i]),
         .q   (Q[i])
      );
   end

   assign QN = ~Q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) SOUT <= 1'b0;
      else     SOUT <= sout_next;
   end

`ifdef FF_MODE_REG_CHG_EN
   // Flags an edge that actually changed Q; reset never raises it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) CHG <= 1'b0;
      else     CHG <= (q_next != Q);
   end
`endif

endmodule

// File: tb/tb_ff_mode_reg.sv
// Directed bench for ff_mode_reg: default-reset and RST_VAL=8'h3C instances share stimulus.
// CHG checks compile only when FF_MODE_REG_CHG_EN is defined.
module tb_ff_mode_reg;
   import ff_mode_pkg::*;

   logic              clk;
   logic              rst;
   logic              en;
   logic [MODE_W-1:0] mode;
   logic [7:0]        d;
   logic              sin;
   logic [7:0]        q, qn, q2, qn2;
   logic              sout, sout2;
`ifdef FF_MODE_REG_CHG_EN
   logic              chg, chg2;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   ff_mode_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_dut (
      .CLK (clk), .RST (rst), .EN (en), .MODE (mode), .D (d), .SIN (sin),
      .Q (q), .QN (qn), .SOUT (sout)
`ifdef FF_MODE_REG_CHG_EN
      , .CHG (chg)
`endif
   );

   ff_mode_reg #(.WIDTH(8), .RST_VAL(8'h3C)) u_dut_rv (
      .CLK (clk), .RST (rst), .EN (en), .MODE (mode), .D (d), .SIN (sin),
      .Q (q2), .QN (qn2), .SOUT (sout2)
`ifdef FF_MODE_REG_CHG_EN
      , .CHG (chg2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] dv, input logic s);
      en = e; mode = m; d = dv; sin = s;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, MODE_HOLD, 8'h00, 1'b0);
      #3;
      check("por_q",     32'(q),     32'h00);
      check("por_qn",    32'(qn),    32'hFF);
      check("por_sout",  32'(sout),  32'h0);
      check("por_q_rv",  32'(q2),    32'h3C);
      check("por_qn_rv", 32'(qn2),   32'hC3);
      tick();
      check("rst_hold_q", 32'(q), 32'h00);
      rst = 1'b0;

      // Load A5, then reset mid-cycle
      drive(1'b1, MODE_LOAD, 8'hA5, 1'b0);
      tick();
      check("load_a5", 32'(q), 32'hA5);
      #2 rst = 1'b1;
      #1;
      check("async_rst_q",    32'(q),  32'h00);
      check("async_rst_qn",   32'(qn), 32'hFF);
      check("async_rst_q_rv", 32'(q2), 32'h3C);
      #1 rst = 1'b0;

      // Load/toggle/set/clear chain
      drive(1'b1, MODE_LOAD, 8'h5A, 1'b0);
      tick(); check("load_5a",   32'(q), 32'h5A);
      drive(1'b1, MODE_TOGGLE, 8'hFF, 1'b0);
      tick(); check("toggle_ff", 32'(q), 32'hA5);
      check("toggle_qn", 32'(qn), 32'h5A);
      drive(1'b1, MODE_SET, 8'h0F, 1'b0);
      tick(); check("set_0f",    32'(q), 32'hAF);
      drive(1'b1, MODE_CLR, 8'h81, 1'b0);
      tick(); check("clr_81",    32'(q), 32'h2E);
      drive(1'b1, MODE_TOGGLE, 8'h00, 1'b0);
      tick(); check("toggle_00", 32'(q), 32'h2E);
      drive(1'b1, MODE_SET, 8'h00, 1'b0);
      tick(); check("set_00",    32'(q), 32'h2E);
      drive(1'b1, MODE_CLR, 8'h00, 1'b0);
      tick(); check("clr_00",    32'(q), 32'h2E);
      drive(1'b1, MODE_HOLD, 8'hFF, 1'b1);
      tick(); check("hold",      32'(q), 32'h2E);
      check("sout_unshifted", 32'(sout), 32'h0);

      // Shift / rotate
      drive(1'b1, MODE_LOAD, 8'h81, 1'b0);
      tick(); check("load_81",   32'(q), 32'h81);
      drive(1'b1, MODE_SHL, 8'h00, 1'b0);
      tick(); check("shl_q",     32'(q), 32'h02);
      check("shl_sout",  32'(sout), 32'h1);
      drive(1'b1, MODE_SHR, 8'h00, 1'b1);
      tick(); check("shr_q",     32'(q), 32'h81);
      check("shr_sout",  32'(sout), 32'h0);
      drive(1'b1, MODE_ROL, 8'h00, 1'b0);
      tick(); check("rol_q",     32'(q), 32'h03);
      check("rol_sout",  32'(sout), 32'h1);

      // Enable low holds everything
      drive(1'b0, MODE_LOAD, 8'hFF, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("en0_q_%0d", i),    32'(q),    32'h03);
         check($sformatf("en0_sout_%0d", i), 32'(sout), 32'h1);
      end
      drive(1'b1, MODE_LOAD, 8'hFF, 1'b1);
      tick(); check("en1_load",  32'(q), 32'hFF);
      check("load_keeps_sout", 32'(sout), 32'h1);
      mode = 3'bxxx;
      tick(); check("mode_x_hold", 32'(q), 32'hFF);

      // Reset during SHL burst, release 0.3 cycle before an edge
      drive(1'b1, MODE_SHL, 8'h00, 1'b0);
      tick(); check("burst1_q", 32'(q), 32'hFE);
      tick(); check("burst2_q", 32'(q), 32'hFC);
      check("burst2_sout", 32'(sout), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("burst_rst_q",    32'(q),    32'h00);
      check("burst_rst_sout", 32'(sout), 32'h0);
      tick();
      check("burst_rst_held", 32'(q), 32'h00);
      sin = 1'b1;
      #6 rst = 1'b0;
      #1;
      check("pre_edge_q", 32'(q), 32'h00);
      tick();
      check("post_rst_shl_q",     32'(q),     32'h01);
      check("post_rst_shl_sout",  32'(sout),  32'h0);
      check("post_rst_shl_q_rv",  32'(q2),    32'h79);
      check("post_rst_shl_so_rv", 32'(sout2), 32'h0);
      tick(); check("shl_sin1_q", 32'(q), 32'h03);
      drive(1'b1, MODE_SHR, 8'h00, 1'b0);
      tick(); check("shr_sin0_q", 32'(q), 32'h01);
      check("shr_sin0_sout", 32'(sout), 32'h1);

`ifdef FF_MODE_REG_CHG_EN
      drive(1'b1, MODE_LOAD, 8'h12, 1'b0);
      tick(); check("chg_load1", 32'(chg), 32'h1);
      tick(); check("chg_load2", 32'(chg), 32'h0);
      drive(1'b1, MODE_TOGGLE, 8'h00, 1'b0);
      tick(); check("chg_tog00", 32'(chg), 32'h0);
      drive(1'b1, MODE_TOGGLE, 8'h01, 1'b0);
      tick(); check("chg_tog01", 32'(chg), 32'h1);
      check("chg_tog01_q", 32'(q), 32'h13);
      drive(1'b0, MODE_LOAD, 8'hFF, 1'b0);
      tick(); check("chg_en0", 32'(chg), 32'h0);
      drive(1'b1, MODE_LOAD, 8'hFF, 1'b0);
      tick(); check("chg_pre_rst", 32'(chg), 32'h1);
      #2 rst = 1'b1;
      #1; check("chg_rst", 32'(chg), 32'h0);
      #1 rst = 1'b0;
      drive(1'b1, MODE_HOLD, 8'h00, 1'b0);
      tick(); check("chg_after_rst", 32'(chg), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
